alternador_bombas: RTL and testbench

- Duty/standby scheduler for a duplex pump station, placed downstream of the level controller.
- Takes a single fill demand and decides which of two pumps runs, alternating pump 0/1 on each completed run.
- Enforces a minimum off time and a minimum run time, so the pumps are not short-cycled.
- Fails over to the healthy pump on a fault and raises a total-failure flag when both pumps are faulted.

---
 rtl/bomba_pkg.sv | 25 ++
 rtl/alternador_bombas_if.sv | 31 +++
 rtl/alternador_bombas_temporizador_sat.sv | 26 ++
 rtl/alternador_bombas.sv | 131 +++++++++++++
 tb/tb_alternador_bombas.sv | 129 ++++++++++++
 5 files changed

// File: rtl/bomba_pkg.sv
// Shared constants for the pump station: scheduler states, pump indices and
// level controller states.
package bomba_pkg;

    // Duty/standby scheduler states.
    typedef enum logic [1:0] {
        REPOSO  = 2'b00,
        MARCHA  = 2'b01,
        CAMBIO  = 2'b10,
        BLOQUEO = 2'b11
    } estado_t;

    // Pump indices.
    localparam logic BOMBA_0 = 1'b0;
    localparam logic BOMBA_1 = 1'b1;

    // Level controller states, shared with the upstream block.
    typedef enum logic [1:0] {
        NIVEL_VACIO  = 2'b00,
        NIVEL_BAJO   = 2'b01,
        NIVEL_LLENO  = 2'b10,
        NIVEL_ALARMA = 2'b11
    } nivel_t;

endpackage

// File: rtl/alternador_bombas_if.sv
// Signal bundle between the level controller side and the pump scheduler.
interface alternador_bombas_if;

    logic       demanda_i;
    logic       alarma_i;
    logic [1:0] falla_i;
    logic [1:0] bomba_o;
    logic       activa_o;
    logic       falla_total_o;

    // Level controller / station side.
    modport master (
        output demanda_i,
        output alarma_i,
        output falla_i,
        input  bomba_o,
        input  activa_o,
        input  falla_total_o
    );

    // Scheduler side.
    modport slave (
        input  demanda_i,
        input  alarma_i,
        input  falla_i,
        output bomba_o,
        output activa_o,
        output falla_total_o
    );

endinterface

// File: rtl/alternador_bombas_temporizador_sat.sv
// Saturating up-counter with synchronous clear, used as the shared dwell timer.
module temporizador_sat #(
    parameter int unsigned W_CNT = 16
) (
    input  logic             ck,
    input  logic             rst_i,
    input  logic             clr_i,
    output logic [W_CNT-1:0] cnt_o
);

    logic [W_CNT-1:0] cnt_q;

    // Clear has priority; otherwise count up and hold at all-ones.
    always_ff @(posedge ck or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != {W_CNT{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/alternador_bombas.sv
// Duty/standby scheduler for a duplex pump station: alternates pumps per
// completed run, enforces minimum off/run times and fails over on faults.
module alternador_bombas
    import bomba_pkg::*;
#(
    parameter int unsigned W_CNT        = 16,
    parameter int unsigned T_REPOSO_MIN = 100,
    parameter int unsigned T_MARCHA_MIN = 50,
    parameter int unsigned T_MUERTO     = 10
) (
    input  logic               ck,
    input  logic               rst_i,
    alternador_bombas_if.slave bus
);

    localparam logic [W_CNT-1:0] LIM_REPOSO = W_CNT'(T_REPOSO_MIN);
    localparam logic [W_CNT-1:0] LIM_MARCHA = W_CNT'(T_MARCHA_MIN - 1);
    localparam logic [W_CNT-1:0] LIM_MUERTO = W_CNT'(T_MUERTO - 1);

    estado_t          estado_q, estado_d;
    logic             act_q, act_d;
    logic             sel_q, sel_d;
    logic [1:0]       bomba_q, bomba_d;
    logic             activa_q, activa_d;
    logic             falla_total_q, falla_total_d;
    logic [W_CNT-1:0] cnt;
    logic             cand;

    // Dwell timer restarts on every state change.
    temporizador_sat #(
        .W_CNT (W_CNT)
    ) u_temporizador (
        .ck    (ck),
        .rst_i (rst_i),
        .clr_i (estado_d != estado_q),
        .cnt_o (cnt)
    );

    // Preferred pump unless it is faulted; the all-faulted case never reaches a start.
    assign cand = bus.falla_i[sel_q] ? ~sel_q : sel_q;

    // State, pump selection and registered Moore outputs.
    always_ff @(posedge ck or negedge rst_i) begin
        if (!rst_i) begin
            estado_q      <= REPOSO;
            act_q         <= BOMBA_0;
            sel_q         <= BOMBA_0;
            bomba_q       <= 2'b00;
            activa_q      <= 1'b0;
            falla_total_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            act_q         <= act_d;
            sel_q         <= sel_d;
            bomba_q       <= bomba_d;
            activa_q      <= activa_d;
            falla_total_q <= falla_total_d;
        end
    end

    // Next state: double fault first, then alarm, then per-state rules.
    always_comb begin
        estado_d = estado_q;
        act_d    = act_q;
        sel_d    = sel_q;
        if (bus.falla_i == 2'b11) begin
            estado_d = BLOQUEO;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (bus.demanda_i && !bus.alarma_i && cnt >= LIM_REPOSO) begin
                        estado_d = MARCHA;
                        act_d    = cand;
                    end
                end
                MARCHA: begin
                    if (bus.alarma_i) begin
                        estado_d = REPOSO;
                    end else if (bus.falla_i[act_q]) begin
                        estado_d = bus.falla_i[~act_q] ? BLOQUEO : CAMBIO;
                    end else if (!bus.demanda_i && cnt >= LIM_MARCHA) begin
                        estado_d = REPOSO;
                        sel_d    = ~act_q;
                    end
                end
                CAMBIO: begin
                    if (bus.alarma_i) begin
                        estado_d = REPOSO;
                    end else if (cnt == LIM_MUERTO) begin
                        if (bus.demanda_i && !bus.falla_i[~act_q]) begin
                            estado_d = MARCHA;
                            act_d    = ~act_q;
                        end else begin
                            estado_d = REPOSO;
                        end
                    end
                end
                BLOQUEO: begin
                    estado_d = REPOSO;
                end
                default: begin
                    estado_d = REPOSO;
                end
            endcase
        end
    end

    // Output values for the state being entered.
    always_comb begin
        bomba_d       = 2'b00;
        activa_d      = activa_q;
        falla_total_d = 1'b0;
        case (estado_d)
            MARCHA: begin
                bomba_d  = act_d ? 2'b10 : 2'b01;
                activa_d = act_d;
            end
            REPOSO:  activa_d = sel_d;
            BLOQUEO: falla_total_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.bomba_o       = bomba_q;
    assign bus.activa_o      = activa_q;
    assign bus.falla_total_o = falla_total_q;

    // Both pumps must never be commanded together.
    a_no_doble: assert property (@(posedge ck) disable iff (!rst_i) bus.bomba_o != 2'b11);

endmodule

// File: tb/tb_alternador_bombas.sv
// Directed scoreboard bench for the pump scheduler with short timing parameters.
module tb_alternador_bombas;

    logic ck;
    logic rst_i;
    int   n_comp;
    int   n_err;
    logic [3:0] sb_q[$];

    alternador_bombas_if bus ();

    alternador_bombas #(
        .W_CNT        (16),
        .T_REPOSO_MIN (4),
        .T_MARCHA_MIN (3),
        .T_MUERTO     (2)
    ) dut (
        .ck    (ck),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Packs an expected output as {falla_total, activa, bomba}.
    function automatic logic [3:0] esp(input logic [1:0] b, input logic a, input logic f);
        return {f, a, b};
    endfunction

    task automatic comprobar(input string tag, input logic [3:0] obs, input logic [3:0] req);
        n_comp++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, req);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic paso(input string tag, input logic d, input logic a, input logic [1:0] f,
                        input logic [3:0] e);
        bus.demanda_i = d;
        bus.alarma_i  = a;
        bus.falla_i   = f;
        sb_q.push_back(e);
        @(posedge ck);
        #1;
        comprobar(tag, {bus.falla_total_o, bus.activa_o, bus.bomba_o}, sb_q.pop_front());
    endtask

    // Both pumps on is illegal in any cycle outside reset.
    always @(negedge ck) begin
        if (rst_i) comprobar("no_11", {3'b000, bus.bomba_o == 2'b11}, 4'h0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_comp        = 0;
        n_err         = 0;
        bus.demanda_i = 1'b0;
        bus.alarma_i  = 1'b0;
        bus.falla_i   = 2'b00;
        rst_i         = 1'b1;
        #1 rst_i = 1'b0;
        #2 comprobar("reset", {bus.falla_total_o, bus.activa_o, bus.bomba_o}, 4'h0);
        repeat (2) @(negedge ck);
        rst_i = 1'b1;

        // First start waits the minimum off time.
        repeat (4) paso("arranque_esp", 1'b1, 1'b0, 2'b00, esp(2'b00, 1'b0, 1'b0));
        paso("arranque_b0", 1'b1, 1'b0, 2'b00, esp(2'b01, 1'b0, 1'b0));
        // Minimum run time, then alternation to pump 1.
        repeat (2) paso("marcha_min", 1'b0, 1'b0, 2'b00, esp(2'b01, 1'b0, 1'b0));
        paso("alterna_sel1", 1'b0, 1'b0, 2'b00, esp(2'b00, 1'b1, 1'b0));
        repeat (4) paso("reposo_sel1", 1'b1, 1'b0, 2'b00, esp(2'b00, 1'b1, 1'b0));
        paso("arranque_b1", 1'b1, 1'b0, 2'b00, esp(2'b10, 1'b1, 1'b0));
        repeat (2) paso("marcha_b1", 1'b0, 1'b0, 2'b00, esp(2'b10, 1'b1, 1'b0));
        paso("alterna_sel0", 1'b0, 1'b0, 2'b00, esp(2'b00, 1'b0, 1'b0));
        repeat (4) paso("reposo_sel0", 1'b1, 1'b0, 2'b00, esp(2'b00, 1'b0, 1'b0));
        paso("arranque_b0_2", 1'b1, 1'b0, 2'b00, esp(2'b01, 1'b0, 1'b0));
        // Fault on the running pump: dead time, then the other pump.
        paso("falla0_cambio", 1'b1, 1'b0, 2'b01, esp(2'b00, 1'b0, 1'b0));
        paso("tiempo_muerto", 1'b1, 1'b0, 2'b01, esp(2'b00, 1'b0, 1'b0));
        paso("relevo_b1", 1'b1, 1'b0, 2'b01, esp(2'b10, 1'b1, 1'b0));
        // Double fault from MARCHA, recovery with full off time.
        repeat (2) paso("bloqueo", 1'b1, 1'b0, 2'b11, esp(2'b00, 1'b1, 1'b1));
        paso("sal_bloqueo", 1'b1, 1'b0, 2'b10, esp(2'b00, 1'b0, 1'b0));
        repeat (4) paso("reposo_post", 1'b1, 1'b0, 2'b10, esp(2'b00, 1'b0, 1'b0));
        paso("arranque_post", 1'b1, 1'b0, 2'b10, esp(2'b01, 1'b0, 1'b0));
        // Alarm on first run cycle: immediate stop, no alternation.
        paso("alarma", 1'b1, 1'b1, 2'b00, esp(2'b00, 1'b0, 1'b0));
        repeat (4) paso("reposo_alarma", 1'b1, 1'b0, 2'b00, esp(2'b00, 1'b0, 1'b0));
        paso("rearranque", 1'b1, 1'b0, 2'b00, esp(2'b01, 1'b0, 1'b0));
        // Double fault from REPOSO.
        paso("alarma2", 1'b1, 1'b1, 2'b00, esp(2'b00, 1'b0, 1'b0));
        paso("bloqueo_rep", 1'b1, 1'b0, 2'b11, esp(2'b00, 1'b0, 1'b1));
        paso("libera", 1'b1, 1'b0, 2'b00, esp(2'b00, 1'b0, 1'b0));
        repeat (4) paso("reposo_libera", 1'b1, 1'b0, 2'b00, esp(2'b00, 1'b0, 1'b0));
        paso("arranque_libera", 1'b1, 1'b0, 2'b00, esp(2'b01, 1'b0, 1'b0));
        // Fault on the idle pump leaves the run alone.
        repeat (2) paso("falla_ajena", 1'b1, 1'b0, 2'b10, esp(2'b01, 1'b0, 1'b0));
        // Fault and demand drop together: fault wins.
        paso("falla_gana", 1'b0, 1'b0, 2'b01, esp(2'b00, 1'b0, 1'b0));
        paso("muerto_sin_dem", 1'b0, 1'b0, 2'b01, esp(2'b00, 1'b0, 1'b0));
        paso("cambio_a_reposo", 1'b0, 1'b0, 2'b01, esp(2'b00, 1'b0, 1'b0));
        // Preferred pump faulted: candidate is pump 1.
        repeat (4) paso("reposo_cand", 1'b1, 1'b0, 2'b01, esp(2'b00, 1'b0, 1'b0));
        paso("arranque_cand1", 1'b1, 1'b0, 2'b01, esp(2'b10, 1'b1, 1'b0));

        // Asynchronous reset mid-run, away from any clock edge.
        #2 rst_i = 1'b0;
        #1 comprobar("reset_async", {bus.falla_total_o, bus.activa_o, bus.bomba_o}, 4'h0);
        repeat (2) @(negedge ck);
        rst_i = 1'b1;
        repeat (4) paso("post_reset_esp", 1'b1, 1'b0, 2'b00, esp(2'b00, 1'b0, 1'b0));
        paso("post_reset_b0", 1'b1, 1'b0, 2'b00, esp(2'b01, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
        $finish;
    end

endmodule
